wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/npc_pkg.sv | 10 +
 rtl/wb_arbiter_if.sv | 43 ++++
 rtl/gpr_scoreboard.sv | 36 +++
 rtl/wb_arbiter.sv | 85 ++++++++
 tb/tb_wb_arbiter.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/npc_pkg.sv
// Shared core definitions: data width, register address width, writeback source ids.
package npc_pkg;
   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   typedef enum logic {
      WB_EXU = 1'b0,
      WB_LSU = 1'b1
   } wb_src_e;
endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback port bundle: two requesters, scoreboard set/query and regfile write side.
interface wb_arbiter_if #(
   parameter int XLEN = 32
);
   import npc_pkg::*;

   logic              exu_valid;
   logic              exu_ready;
   logic [REG_AW-1:0] exu_rd;
   logic [XLEN-1:0]   exu_data;

   logic              lsu_valid;
   logic              lsu_ready;
   logic [REG_AW-1:0] lsu_rd;
   logic [XLEN-1:0]   lsu_data;

   logic              sb_set;
   logic [REG_AW-1:0] sb_set_rd;
   logic [REG_AW-1:0] rs1_addr;
   logic [REG_AW-1:0] rs2_addr;
   logic              rs1_busy;
   logic              rs2_busy;

   logic              rf_wen;
   logic [REG_AW-1:0] rf_waddr;
   logic [XLEN-1:0]   rf_wdata;

   modport master (
      output exu_valid, exu_rd, exu_data,
      output lsu_valid, lsu_rd, lsu_data,
      output sb_set, sb_set_rd, rs1_addr, rs2_addr,
      input  exu_ready, lsu_ready, rs1_busy, rs2_busy,
      input  rf_wen, rf_waddr, rf_wdata
   );

   modport slave (
      input  exu_valid, exu_rd, exu_data,
      input  lsu_valid, lsu_rd, lsu_data,
      input  sb_set, sb_set_rd, rs1_addr, rs2_addr,
      output exu_ready, lsu_ready, rs1_busy, rs2_busy,
      output rf_wen, rf_waddr, rf_wdata
   );
endinterface

// File: rtl/gpr_scoreboard.sv
// Pending-load busy bits, one per GPR; x0 is never busy.
module gpr_scoreboard #(
   parameter int NREG = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_set,
   input  logic [npc_pkg::REG_AW-1:0] i_set_rd,
   input  logic                      i_clr,
   input  logic [npc_pkg::REG_AW-1:0] i_clr_rd,
   input  logic [npc_pkg::REG_AW-1:0] i_rs1_addr,
   input  logic [npc_pkg::REG_AW-1:0] i_rs2_addr,
   output logic                      o_rs1_busy,
   output logic                      o_rs2_busy
);
   import npc_pkg::*;

   logic [NREG-1:0] r_busy;
   logic [NREG-1:0] w_busy_nxt;

   // Set is applied after clear so a same-register collision leaves the bit set.
   always_comb begin
      w_busy_nxt = r_busy;
      if (i_clr) w_busy_nxt[i_clr_rd] = 1'b0;
      if (i_set) w_busy_nxt[i_set_rd] = 1'b1;
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_busy <= '0;
      else     r_busy <= w_busy_nxt;
   end

   assign o_rs1_busy = r_busy[i_rs1_addr];
   assign o_rs2_busy = r_busy[i_rs2_addr];
endmodule

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter between ALU and load unit, with registered regfile write port.
module wb_arbiter #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input  logic         clk,
   input  logic         rst,
   wb_arbiter_if.slave  bus
);
   import npc_pkg::*;

   wb_src_e           r_last_grant;
   wb_src_e           w_last_grant_nxt;
   logic              w_exu_gnt;
   logic              w_lsu_gnt;
   logic              r_wen;
   logic [REG_AW-1:0] r_waddr;
   logic [XLEN-1:0]   r_wdata;
   logic              w_rs1_busy;
   logic              w_rs2_busy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_last_grant <= WB_LSU;
      else     r_last_grant <= w_last_grant_nxt;
   end

   // Ready equals grant; contention goes to the source that did not win last.
   always_comb begin
      w_exu_gnt        = 1'b0;
      w_lsu_gnt        = 1'b0;
      w_last_grant_nxt = r_last_grant;
      if (!rst) begin
         if (bus.exu_valid && bus.lsu_valid) begin
            w_exu_gnt = (r_last_grant == WB_LSU);
            w_lsu_gnt = (r_last_grant == WB_EXU);
         end else begin
            w_exu_gnt = bus.exu_valid;
            w_lsu_gnt = bus.lsu_valid;
         end
      end
      if (w_exu_gnt) w_last_grant_nxt = WB_EXU;
      if (w_lsu_gnt) w_last_grant_nxt = WB_LSU;
   end

   // Address/data hold when idle; a write to x0 completes the handshake but never asserts wen.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wen   <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
      end else begin
         r_wen <= 1'b0;
         if (w_exu_gnt) begin
            r_wen   <= |bus.exu_rd;
            r_waddr <= bus.exu_rd;
            r_wdata <= bus.exu_data;
         end else if (w_lsu_gnt) begin
            r_wen   <= |bus.lsu_rd;
            r_waddr <= bus.lsu_rd;
            r_wdata <= bus.lsu_data;
         end
      end
   end

   gpr_scoreboard #(.NREG(NREG)) u_sb (
      .clk        (clk),
      .rst        (rst),
      .i_set      (bus.sb_set),
      .i_set_rd   (bus.sb_set_rd),
      .i_clr      (w_lsu_gnt),
      .i_clr_rd   (bus.lsu_rd),
      .i_rs1_addr (bus.rs1_addr),
      .i_rs2_addr (bus.rs2_addr),
      .o_rs1_busy (w_rs1_busy),
      .o_rs2_busy (w_rs2_busy)
   );

   assign bus.exu_ready = w_exu_gnt;
   assign bus.lsu_ready = w_lsu_gnt;
   assign bus.rs1_busy  = w_rs1_busy;
   assign bus.rs2_busy  = w_rs2_busy;
   assign bus.rf_wen    = r_wen;
   assign bus.rf_waddr  = r_waddr;
   assign bus.rf_wdata  = r_wdata;
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_wb_arbiter;
   import npc_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   wb_arbiter_if #(.XLEN(XLEN)) bus();
   wb_arbiter #(.XLEN(XLEN), .NREG(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

   always #5 clk = ~clk;

   // Behavioural model: who wins this cycle, what the regfile sees next, which regs await loads.
   bit          m_last_lsu;
   bit [31:0]   m_busy;
   bit          m_wen;
   logic [4:0]  m_waddr;
   logic [31:0] m_wdata;

   // 0 = nobody, 1 = EXU, 2 = LSU
   function automatic int m_grant();
      if (rst) return 0;
      if (bus.exu_valid && bus.lsu_valid) return m_last_lsu ? 1 : 2;
      if (bus.exu_valid) return 1;
      if (bus.lsu_valid) return 2;
      return 0;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_last_lsu <= 1'b1;
         m_busy     <= '0;
         m_wen      <= 1'b0;
         m_waddr    <= '0;
         m_wdata    <= '0;
      end else begin
         m_wen <= 1'b0;
         case (m_grant())
            1: begin
               m_wen <= (bus.exu_rd != 0); m_waddr <= bus.exu_rd; m_wdata <= bus.exu_data;
               m_last_lsu <= 1'b0;
            end
            2: begin
               m_wen <= (bus.lsu_rd != 0); m_waddr <= bus.lsu_rd; m_wdata <= bus.lsu_data;
               m_last_lsu <= 1'b1;
               m_busy[bus.lsu_rd] <= 1'b0;
            end
            default: ;
         endcase
         if (bus.sb_set && bus.sb_set_rd != 0) m_busy[bus.sb_set_rd] <= 1'b1;
      end
   end

   task automatic idle();
      bus.exu_valid = 0; bus.exu_rd = 0; bus.exu_data = 0;
      bus.lsu_valid = 0; bus.lsu_rd = 0; bus.lsu_data = 0;
      bus.sb_set = 0; bus.sb_set_rd = 0; bus.rs1_addr = 0; bus.rs2_addr = 0;
   endtask

   // Leaves the bench at posedge+1 with reset released and inputs idle.
   task automatic do_reset();
      idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      idle();
      bus.exu_valid = 1; bus.lsu_valid = 1; bus.sb_set = 1; bus.sb_set_rd = 3; bus.rs1_addr = 3;
      @(negedge clk);
      checks++; if (bus.exu_ready !== 1'b0) begin errors++; $display("FAIL rst_exu_ready got=%0b exp=0", bus.exu_ready); end
      checks++; if (bus.lsu_ready !== 1'b0) begin errors++; $display("FAIL rst_lsu_ready got=%0b exp=0", bus.lsu_ready); end
      checks++; if (bus.rf_wen !== 1'b0) begin errors++; $display("FAIL rst_wen got=%0b exp=0", bus.rf_wen); end
      checks++; if (bus.rf_waddr !== 5'd0) begin errors++; $display("FAIL rst_waddr got=%0d exp=0", bus.rf_waddr); end
      checks++; if (bus.rf_wdata !== 32'd0) begin errors++; $display("FAIL rst_wdata got=%0h exp=0", bus.rf_wdata); end
      @(posedge clk); @(negedge clk);
      checks++; if (bus.rs1_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%0b exp=0", bus.rs1_busy); end
      idle();
      rst = 1'b0;
      @(posedge clk); #1;
      checks++; if (bus.rf_wen !== 1'b0) begin errors++; $display("FAIL rst_first_cycle_wen got=%0b exp=0", bus.rf_wen); end
   endtask

   task automatic test_exu_only();
      do_reset();
      bus.exu_valid = 1; bus.exu_rd = 5; bus.exu_data = 32'h1234;
      @(negedge clk);
      checks++; if (bus.exu_ready !== 1'b1) begin errors++; $display("FAIL exu_only_ready got=%0b exp=1", bus.exu_ready); end
      checks++; if (bus.lsu_ready !== 1'b0) begin errors++; $display("FAIL exu_only_lsu_ready got=%0b exp=0", bus.lsu_ready); end
      @(posedge clk); #1;
      bus.exu_valid = 0;
      checks++; if (bus.rf_wen !== 1'b1) begin errors++; $display("FAIL exu_only_wen got=%0b exp=1", bus.rf_wen); end
      checks++; if (bus.rf_waddr !== 5'd5) begin errors++; $display("FAIL exu_only_waddr got=%0d exp=5", bus.rf_waddr); end
      checks++; if (bus.rf_wdata !== 32'h1234) begin errors++; $display("FAIL exu_only_wdata got=%0h exp=1234", bus.rf_wdata); end
      @(posedge clk); #1;
      checks++; if (bus.rf_wen !== 1'b0) begin errors++; $display("FAIL idle_wen got=%0b exp=0", bus.rf_wen); end
      checks++; if (bus.rf_waddr !== 5'd5) begin errors++; $display("FAIL idle_waddr_hold got=%0d exp=5", bus.rf_waddr); end
      checks++; if (bus.rf_wdata !== 32'h1234) begin errors++; $display("FAIL idle_wdata_hold got=%0h exp=1234", bus.rf_wdata); end
   endtask

   task automatic test_round_robin();
      int exp_src[4] = '{1, 2, 1, 2};
      int got;
      do_reset();
      bus.exu_valid = 1; bus.exu_rd = 1; bus.exu_data = 32'hE0;
      bus.lsu_valid = 1; bus.lsu_rd = 2; bus.lsu_data = 32'hA0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         got = (bus.exu_ready ? 1 : 0) + (bus.lsu_ready ? 2 : 0);
         checks++; if (got != exp_src[i]) begin errors++; $display("FAIL rr_grant%0d got=%0d exp=%0d", i, got, exp_src[i]); end
         @(posedge clk); #1;
         checks++; if (bus.rf_waddr !== 5'(exp_src[i])) begin errors++; $display("FAIL rr_waddr%0d got=%0d exp=%0d", i, bus.rf_waddr, exp_src[i]); end
      end
      idle();
   endtask

   task automatic test_scoreboard();
      do_reset();
      bus.sb_set = 1; bus.sb_set_rd = 7; bus.rs1_addr = 7;
      @(negedge clk);
      checks++; if (bus.rs1_busy !== 1'b0) begin errors++; $display("FAIL sb_before_edge got=%0b exp=0", bus.rs1_busy); end
      @(posedge clk); #1; bus.sb_set = 0;
      @(negedge clk);
      checks++; if (bus.rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_set7 got=%0b exp=1", bus.rs1_busy); end
      @(posedge clk); #1; bus.lsu_valid = 1; bus.lsu_rd = 7; bus.lsu_data = 32'h55;
      @(negedge clk);
      checks++; if (bus.lsu_ready !== 1'b1) begin errors++; $display("FAIL sb_lsu_ready got=%0b exp=1", bus.lsu_ready); end
      checks++; if (bus.rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_no_forward got=%0b exp=1", bus.rs1_busy); end
      @(posedge clk); #1; bus.lsu_valid = 0;
      @(negedge clk);
      checks++; if (bus.rs1_busy !== 1'b0) begin errors++; $display("FAIL sb_clear7 got=%0b exp=0", bus.rs1_busy); end
      @(posedge clk); #1; bus.sb_set = 1; bus.sb_set_rd = 7; bus.lsu_valid = 1; bus.lsu_rd = 7;
      @(posedge clk); #1; bus.sb_set = 0; bus.lsu_valid = 0;
      @(negedge clk);
      checks++; if (bus.rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_set_wins got=%0b exp=1", bus.rs1_busy); end
      @(posedge clk); #1; bus.sb_set = 1; bus.sb_set_rd = 9; bus.lsu_valid = 1; bus.lsu_rd = 7; bus.rs2_addr = 9;
      @(posedge clk); #1; bus.sb_set = 0; bus.lsu_valid = 0;
      @(negedge clk);
      checks++; if (bus.rs1_busy !== 1'b0) begin errors++; $display("FAIL sb_diff_clr got=%0b exp=0", bus.rs1_busy); end
      checks++; if (bus.rs2_busy !== 1'b1) begin errors++; $display("FAIL sb_diff_set got=%0b exp=1", bus.rs2_busy); end
      @(posedge clk); #1; bus.sb_set = 1; bus.sb_set_rd = 9;
      @(posedge clk); #1; bus.sb_set = 0;
      @(negedge clk);
      checks++; if (bus.rs2_busy !== 1'b1) begin errors++; $display("FAIL sb_reset_busy got=%0b exp=1", bus.rs2_busy); end
      @(posedge clk); #1;
      bus.sb_set = 1; bus.sb_set_rd = 0; bus.rs1_addr = 0;
      bus.exu_valid = 1; bus.exu_rd = 0; bus.exu_data = 32'hABC;
      @(negedge clk);
      checks++; if (bus.exu_ready !== 1'b1) begin errors++; $display("FAIL x0_ready got=%0b exp=1", bus.exu_ready); end
      @(posedge clk); #1; bus.sb_set = 0; bus.exu_valid = 0;
      checks++; if (bus.rf_wen !== 1'b0) begin errors++; $display("FAIL x0_wen got=%0b exp=0", bus.rf_wen); end
      @(negedge clk);
      checks++; if (bus.rs1_busy !== 1'b0) begin errors++; $display("FAIL x0_busy got=%0b exp=0", bus.rs1_busy); end
      idle();
   endtask

   task automatic test_random();
      int  g;
      bit  e_done = 0;
      bit  l_done = 0;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         // A pending request holds its payload until granted.
         if (!bus.exu_valid || e_done) begin
            bus.exu_valid = 1'($urandom_range(0, 1)); bus.exu_rd = 5'($urandom_range(0, 7)); bus.exu_data = $urandom;
         end
         if (!bus.lsu_valid || l_done) begin
            bus.lsu_valid = 1'($urandom_range(0, 1)); bus.lsu_rd = 5'($urandom_range(0, 7)); bus.lsu_data = $urandom;
         end
         bus.sb_set    = ($urandom_range(0, 2) == 0);
         bus.sb_set_rd = 5'($urandom_range(0, 7));
         bus.rs1_addr  = 5'($urandom_range(0, 7));
         bus.rs2_addr  = 5'($urandom_range(0, 31));
         @(negedge clk);
         g = m_grant();
         checks++; if (bus.exu_ready !== (g == 1)) begin errors++; $display("FAIL rnd%0d_exu_ready got=%0b exp=%0b", i, bus.exu_ready, g == 1); end
         checks++; if (bus.lsu_ready !== (g == 2)) begin errors++; $display("FAIL rnd%0d_lsu_ready got=%0b exp=%0b", i, bus.lsu_ready, g == 2); end
         checks++; if (bus.rs1_busy !== m_busy[bus.rs1_addr]) begin errors++; $display("FAIL rnd%0d_rs1_busy got=%0b exp=%0b", i, bus.rs1_busy, m_busy[bus.rs1_addr]); end
         checks++; if (bus.rs2_busy !== m_busy[bus.rs2_addr]) begin errors++; $display("FAIL rnd%0d_rs2_busy got=%0b exp=%0b", i, bus.rs2_busy, m_busy[bus.rs2_addr]); end
         e_done = (g == 1);
         l_done = (g == 2);
         @(posedge clk); #1;
         checks++; if (bus.rf_wen !== m_wen) begin errors++; $display("FAIL rnd%0d_wen got=%0b exp=%0b", i, bus.rf_wen, m_wen); end
         if (m_wen) begin
            checks++; if (bus.rf_waddr !== m_waddr) begin errors++; $display("FAIL rnd%0d_waddr got=%0d exp=%0d", i, bus.rf_waddr, m_waddr); end
            checks++; if (bus.rf_wdata !== m_wdata) begin errors++; $display("FAIL rnd%0d_wdata got=%0h exp=%0h", i, bus.rf_wdata, m_wdata); end
         end
      end
      idle();
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.sb_set = 1; bus.sb_set_rd = 3; bus.rs1_addr = 3;
      @(posedge clk); #1;
      bus.sb_set = 0; bus.exu_valid = 1; bus.exu_rd = 4; bus.exu_data = 32'hBEEF;
      @(posedge clk); #1;
      bus.exu_valid = 0;
      checks++; if (bus.rf_wen !== 1'b1) begin errors++; $display("FAIL mid_pre_wen got=%0b exp=1", bus.rf_wen); end
      checks++; if (bus.rs1_busy !== 1'b1) begin errors++; $display("FAIL mid_pre_busy got=%0b exp=1", bus.rs1_busy); end
      #2 rst = 1'b1;
      #1;
      checks++; if (bus.rf_wen !== 1'b0) begin errors++; $display("FAIL mid_async_wen got=%0b exp=0", bus.rf_wen); end
      checks++; if (bus.rf_waddr !== 5'd0) begin errors++; $display("FAIL mid_async_waddr got=%0d exp=0", bus.rf_waddr); end
      checks++; if (bus.rf_wdata !== 32'd0) begin errors++; $display("FAIL mid_async_wdata got=%0h exp=0", bus.rf_wdata); end
      checks++; if (bus.rs1_busy !== 1'b0) begin errors++; $display("FAIL mid_async_busy got=%0b exp=0", bus.rs1_busy); end
      bus.exu_valid = 1; bus.lsu_valid = 1;
      #1;
      checks++; if (bus.exu_ready !== 1'b0 || bus.lsu_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got=%0b%0b exp=00", bus.exu_ready, bus.lsu_ready); end
      @(negedge clk);
      idle();
      rst = 1'b0;
      @(posedge clk); #1;
      checks++; if (bus.rf_wen !== 1'b0) begin errors++; $display("FAIL mid_after_rst_wen got=%0b exp=0", bus.rf_wen); end
   endtask

   initial begin
      test_reset();
      test_exu_only();
      test_round_robin();
      test_scoreboard();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end
endmodule
